// File: rtl/mcs4_clkgen_seq.sv
// MCS-4 two-phase clock generator with power-on-clear sequencer.
// Define MCS4_CLKGEN_SYNC_EN to add the bench-only sync output.
module mcs4_clkgen_seq #(
  parameter int CYCLE_TICKS = 27,
  parameter int PHI1_TICKS  = 8,
  parameter int GAP12_TICKS = 2,
  parameter int PHI2_TICKS  = 8,
  parameter int POC_CYCLES  = 275,
  parameter int CNT_W       = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             poc_req,
  output logic             clk1,
  output logic             clk2,
  output logic             poc,
  output logic             clk1_rise,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef MCS4_CLKGEN_SYNC_EN
  ,
  output logic             sync
`endif
);

  localparam int TW =
    (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
  localparam int C2S_I = PHI1_TICKS + GAP12_TICKS;
  localparam int C2E_I = C2S_I + PHI2_TICKS;

  localparam logic [TW-1:0] LAST = TW'(CYCLE_TICKS - 1);
  localparam logic [TW-1:0] P1   = TW'(PHI1_TICKS);
  localparam logic [TW-1:0] C2S  = TW'(C2S_I);
  localparam logic [TW-1:0] C2E  = TW'(C2E_I);

  localparam logic [CNT_W-1:0] POC_LIM =
    CNT_W'(POC_CYCLES);

  generate
    if (PHI1_TICKS < 1 || PHI2_TICKS < 1 ||
        GAP12_TICKS < 1 ||
        C2E_I > CYCLE_TICKS - 1) begin : g_bad_timing
      $error("mcs4_clkgen_seq: illegal phase timing");
    end
  endgenerate

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]    tick_q, tick_d;
  logic             clk1_q, clk1_d;
  logic             clk2_q, clk2_d;
  logic             rise_q, rise_d;
  logic             poc_q, poc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  logic wrap;
  logic rise;
  logic stall;

  // Outputs decode the next tick so they toggle cleanly off flops.
  always_comb begin
    wrap  = (tick_q == LAST);
    rise  = wrap && enable;
    stall = wrap && !enable;

    if (wrap) begin
      tick_d = enable ? '0 : LAST;
    end else begin
      tick_d = tick_q + TW'(1);
    end

    clk1_d = (tick_d < P1);
    clk2_d = (tick_d >= C2S) && (tick_d < C2E);
    rise_d = rise;
    cnt_d  = rise ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    poc_d   = poc_q;
    pcnt_d  = pcnt_q;
    if (!stall) begin
      unique case (state_q)
        HOLD: begin
          if (rise) begin
            // The entry rise is itself the first POC clock.
            if (POC_CYCLES == 0) begin
              state_d = RUN;
              poc_d   = 1'b0;
            end else begin
              state_d = COUNT;
              pcnt_d  = CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (poc_req) begin
            pcnt_d = '0;
          end else if (rise) begin
            if (pcnt_q == POC_LIM) begin
              state_d = RUN;
              poc_d   = 1'b0;
            end else begin
              pcnt_d = pcnt_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (poc_req) begin
            state_d = COUNT;
            poc_d   = 1'b1;
            pcnt_d  = '0;
          end
        end
        default: begin
          state_d = HOLD;
          poc_d   = 1'b1;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tick_q  <= LAST;
      clk1_q  <= 1'b0;
      clk2_q  <= 1'b0;
      rise_q  <= 1'b0;
      poc_q   <= 1'b1;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      state_q <= HOLD;
    end else begin
      tick_q  <= tick_d;
      clk1_q  <= clk1_d;
      clk2_q  <= clk2_d;
      rise_q  <= rise_d;
      poc_q   <= poc_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      state_q <= state_d;
    end
  end

  assign clk1      = clk1_q;
  assign clk2      = clk2_q;
  assign clk1_rise = rise_q;
  assign poc       = poc_q;
  assign cycle_cnt = cnt_q;

`ifdef MCS4_CLKGEN_SYNC_EN
  logic [2:0] phase_q, phase_d;
  logic       sync_q, sync_d;

  // Phase 0 (A1) is the clock on which poc falls.
  always_comb begin
    phase_d = phase_q;
    sync_d  = sync_q;
    if (poc_d) begin
      phase_d = '0;
      sync_d  = 1'b0;
    end else if (rise) begin
      phase_d = poc_q ? 3'd0 : phase_q + 3'd1;
      sync_d  = (phase_d == 3'd7);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      phase_q <= '0;
      sync_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign sync = sync_q;
`endif

endmodule

// File: tb/tb_mcs4_clkgen_seq.sv
// Directed bench for mcs4_clkgen_seq: waveform, POC,
// enable stop/start, mid-run reset and optional sync.
module tb_mcs4_clkgen_seq;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        poc_req;
  logic        clk1;
  logic        clk2;
  logic        poc;
  logic        clk1_rise;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int cur;

  always #5 sysclk = ~sysclk;

`ifdef MCS4_CLKGEN_SYNC_EN
  logic        sync_m;
  logic        reset_s;
  logic        preq_s;
  logic        s_clk1, s_clk2, s_poc, s_rise, s_sync;
  logic [15:0] s_cnt;
`endif

  mcs4_clkgen_seq u_dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .poc_req   (poc_req),
    .clk1      (clk1),
    .clk2      (clk2),
    .poc       (poc),
    .clk1_rise (clk1_rise),
    .cycle_cnt (cycle_cnt)
`ifdef MCS4_CLKGEN_SYNC_EN
    ,
    .sync      (sync_m)
`endif
  );

`ifdef MCS4_CLKGEN_SYNC_EN
  mcs4_clkgen_seq #(.POC_CYCLES(4)) u_sync (
    .sysclk    (sysclk),
    .reset     (reset_s),
    .enable    (enable),
    .poc_req   (preq_s),
    .clk1      (s_clk1),
    .clk2      (s_clk2),
    .poc       (s_poc),
    .clk1_rise (s_rise),
    .cycle_cnt (s_cnt),
    .sync      (s_sync)
  );
`endif

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    poc_req = 1'b0;
    repeat (3) step();
    checks++;
    if (clk1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_clk1 got %b want 0", clk1);
    end
    checks++;
    if (clk2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_clk2 got %b want 0", clk2);
    end
    checks++;
    if (poc !== 1'b1) begin
      errors++;
      $display("FAIL rst_poc got %b want 1", poc);
    end
    checks++;
    if (clk1_rise !== 1'b0) begin
      errors++;
      $display("FAIL rst_rise got %b want 0", clk1_rise);
    end
    checks++;
    if (cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d want 0", cycle_cnt);
    end
    reset = 1'b0;
    step();
    checks++;
    if (clk1 !== 1'b1 || clk1_rise !== 1'b1) begin
      errors++;
      $display("FAIL first_edge clk1=%b rise=%b want 1 1",
               clk1, clk1_rise);
    end
    checks++;
    if (cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL first_cnt got %0d want 1", cycle_cnt);
    end
    checks++;
    if (poc !== 1'b1) begin
      errors++;
      $display("FAIL first_poc got %b want 1", poc);
    end
    cur = 1;
  endtask

  task automatic test_startup(input int ncyc);
    int  fall;
    bit  e1, e2, er, ep;
    fall = -1;
    for (int c = cur; c < cur + ncyc; c++) begin
      for (int t = 0; t < 27; t++) begin
        e1 = (t < 8);
        e2 = (t >= 10 && t < 18);
        er = (t == 0);
        ep = (c < 276);
        checks++;
        if (clk1 !== e1) begin
          errors++;
          $display("FAIL clk1 c=%0d t=%0d got %b want %b",
                   c, t, clk1, e1);
        end
        checks++;
        if (clk2 !== e2) begin
          errors++;
          $display("FAIL clk2 c=%0d t=%0d got %b want %b",
                   c, t, clk2, e2);
        end
        checks++;
        if (clk1_rise !== er) begin
          errors++;
          $display("FAIL rise c=%0d t=%0d got %b want %b",
                   c, t, clk1_rise, er);
        end
        checks++;
        if ((clk1 & clk2) !== 1'b0) begin
          errors++;
          $display("FAIL overlap c=%0d t=%0d got 1 want 0",
                   c, t);
        end
        checks++;
        if (cycle_cnt !== 16'(c)) begin
          errors++;
          $display("FAIL cnt c=%0d t=%0d got %0d want %0d",
                   c, t, cycle_cnt, c);
        end
        checks++;
        if (poc !== ep) begin
          errors++;
          $display("FAIL poc c=%0d t=%0d got %b want %b",
                   c, t, poc, ep);
        end
        if (fall < 0 && poc === 1'b0) fall = c;
        step();
      end
    end
    cur += ncyc;
    checks++;
    if (fall !== 276) begin
      errors++;
      $display("FAIL poc_fall_cnt got %0d want 276", fall);
    end
  endtask

  task automatic test_poc_req(input int ncyc,
                              input int r1,
                              input int r2,
                              input int fall_exp);
    int fall;
    bit ep;
    fall = -1;
    for (int c = cur; c < cur + ncyc; c++) begin
      for (int t = 0; t < 27; t++) begin
        if (c == r1) ep = (t >= 6);
        else         ep = (c < fall_exp);
        checks++;
        if (poc !== ep) begin
          errors++;
          $display("FAIL req_poc c=%0d t=%0d got %b want %b",
                   c, t, poc, ep);
        end
        checks++;
        if (cycle_cnt !== 16'(c)) begin
          errors++;
          $display("FAIL req_cnt c=%0d t=%0d got %0d want %0d",
                   c, t, cycle_cnt, c);
        end
        if (fall < 0 && c > r1 && poc === 1'b0) fall = c;
        poc_req = (t == 5) && (c == r1 || c == r2);
        step();
      end
    end
    poc_req = 1'b0;
    cur += ncyc;
    checks++;
    if (fall !== fall_exp) begin
      errors++;
      $display("FAIL req_fall_cnt got %0d want %0d",
               fall, fall_exp);
    end
  endtask

  task automatic test_enable();
    bit e1, e2;
    for (int t = 0; t < 27; t++) begin
      e1 = (t < 8);
      e2 = (t >= 10 && t < 18);
      checks++;
      if (clk1 !== e1 || clk2 !== e2) begin
        errors++;
        $display("FAIL en_finish t=%0d got %b%b want %b%b",
                 t, clk1, clk2, e1, e2);
      end
      checks++;
      if (cycle_cnt !== 16'(cur)) begin
        errors++;
        $display("FAIL en_cnt t=%0d got %0d want %0d",
                 t, cycle_cnt, cur);
      end
      if (t == 3) enable = 1'b0;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (clk1 !== 1'b0 || clk2 !== 1'b0 ||
          clk1_rise !== 1'b0) begin
        errors++;
        $display("FAIL stop_out i=%0d got %b%b%b want 000",
                 i, clk1, clk2, clk1_rise);
      end
      checks++;
      if (cycle_cnt !== 16'(cur) || poc !== 1'b0) begin
        errors++;
        $display("FAIL stop_frz i=%0d got %0d/%b want %0d/0",
                 i, cycle_cnt, poc, cur);
      end
      step();
    end
    enable = 1'b1;
    step();
    cur++;
    checks++;
    if (clk1 !== 1'b1 || clk1_rise !== 1'b1) begin
      errors++;
      $display("FAIL reen_rise got %b%b want 11",
               clk1, clk1_rise);
    end
    checks++;
    if (cycle_cnt !== 16'(cur)) begin
      errors++;
      $display("FAIL reen_cnt got %0d want %0d",
               cycle_cnt, cur);
    end
  endtask

  task automatic test_reset_mid();
    repeat (12) step();
    checks++;
    if (clk2 !== 1'b1) begin
      errors++;
      $display("FAIL mid_clk2 got %b want 1", clk2);
    end
    reset   = 1'b1;
    poc_req = 1'b1;
    step();
    checks++;
    if (clk1 !== 1'b0 || clk2 !== 1'b0 ||
        clk1_rise !== 1'b0) begin
      errors++;
      $display("FAIL mrst_clk got %b%b%b want 000",
               clk1, clk2, clk1_rise);
    end
    checks++;
    if (poc !== 1'b1 || cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mrst_poc got %b/%0d want 1/0",
               poc, cycle_cnt);
    end
    reset   = 1'b0;
    poc_req = 1'b0;
    step();
    cur = 1;
    checks++;
    if (clk1_rise !== 1'b1 || cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mrst_first got %b/%0d want 1/1",
               clk1_rise, cycle_cnt);
    end
  endtask

`ifdef MCS4_CLKGEN_SYNC_EN
  task automatic test_sync();
    bit es, ep;
    reset_s = 1'b0;
    step();
    for (int c = 1; c <= 30; c++) begin
      for (int t = 0; t < 27; t++) begin
        es = (c == 12 || c == 20 || c == 28);
        ep = (c < 5);
        checks++;
        if (s_sync !== es) begin
          errors++;
          $display("FAIL sync c=%0d t=%0d got %b want %b",
                   c, t, s_sync, es);
        end
        checks++;
        if (s_poc !== ep || s_cnt !== 16'(c)) begin
          errors++;
          $display("FAIL sync_poc c=%0d got %b/%0d want %b/%0d",
                   c, s_poc, s_cnt, ep, c);
        end
        step();
      end
    end
  endtask
`endif

  initial begin
`ifdef MCS4_CLKGEN_SYNC_EN
    reset_s = 1'b1;
    preq_s  = 1'b0;
`endif
    test_reset();
    test_startup(399);
    test_poc_req(300, 400, 0, 676);
    test_poc_req(400, 700, 800, 1076);
    test_enable();
    test_reset_mid();
    test_startup(280);
`ifdef MCS4_CLKGEN_SYNC_EN
    test_sync();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
